// File: rtl/letc_core_hazard_ctrl_if.sv
// Decode, writeback and back-end status into the hazard controller, and the
// per-stage stall/flush/issue controls out of it.
interface letc_core_hazard_ctrl_if;
  logic       d_valid;
  logic [4:0] d_rs1_idx;
  logic [4:0] d_rs2_idx;
  logic       d_rs1_used;
  logic       d_rs2_used;
  logic [4:0] d_rd_idx;
  logic       d_rd_we;
  logic       d_serialize;
  logic       wb_valid;
  logic       wb_rd_we;
  logic [4:0] wb_rd_idx;
  logic       backend_empty;
  logic       redirect;
  logic       mem_stall;

  logic       stall_f1;
  logic       stall_f2;
  logic       stall_d;
  logic       stall_e1;
  logic       stall_e2;
  logic       flush_f1;
  logic       flush_f2;
  logic       flush_d;
  logic       d_issue;

  modport master (
    output d_valid, d_rs1_idx, d_rs2_idx, d_rs1_used, d_rs2_used,
           d_rd_idx, d_rd_we, d_serialize, wb_valid, wb_rd_we, wb_rd_idx,
           backend_empty, redirect, mem_stall,
    input  stall_f1, stall_f2, stall_d, stall_e1, stall_e2,
           flush_f1, flush_f2, flush_d, d_issue
  );

  modport slave (
    input  d_valid, d_rs1_idx, d_rs2_idx, d_rs1_used, d_rs2_used,
           d_rd_idx, d_rd_we, d_serialize, wb_valid, wb_rd_we, wb_rd_idx,
           backend_empty, redirect, mem_stall,
    output stall_f1, stall_f2, stall_d, stall_e1, stall_e2,
           flush_f1, flush_f2, flush_d, d_issue
  );
endinterface

// File: rtl/letc_core_hazard_ctrl.sv
// LETC pipeline sequencing: register scoreboard, CSR/fence drain FSM and
// conversion of redirect / memory back-pressure into stage stalls and flushes.
module letc_core_hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  letc_core_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, DRAIN} ser_state_e;

  ser_state_e       state;
  logic [CNT_W-1:0] cnt [32];

  logic raw_hz, sat_hz, ser_hz, d_hz, hold_d, issue, inc, dec;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    raw_hz = bus.d_valid &
             ((bus.d_rs1_used & (cnt[bus.d_rs1_idx] != '0)) |
              (bus.d_rs2_used & (cnt[bus.d_rs2_idx] != '0)));
    sat_hz = bus.d_valid & bus.d_rd_we & (bus.d_rd_idx != 5'd0) &
             (cnt[bus.d_rd_idx] == CNT_MAX);
    ser_hz = (state == DRAIN) |
             (bus.d_valid & bus.d_serialize & ~bus.backend_empty);
    d_hz   = raw_hz | sat_hz | ser_hz;
    hold_d = bus.mem_stall | d_hz;
    issue  = bus.d_valid & ~hold_d & ~bus.redirect;
    inc    = issue & bus.d_rd_we & (bus.d_rd_idx != 5'd0);
    dec    = bus.wb_valid & bus.wb_rd_we & (bus.wb_rd_idx != 5'd0);
  end

  // Flush beats stall: a redirect releases every front-end stall.
  assign bus.stall_e1 = bus.mem_stall;
  assign bus.stall_e2 = bus.mem_stall;
  assign bus.stall_d  = hold_d & ~bus.redirect;
  assign bus.stall_f2 = hold_d & ~bus.redirect;
  assign bus.stall_f1 = hold_d & ~bus.redirect;
  assign bus.flush_f1 = bus.redirect;
  assign bus.flush_f2 = bus.redirect;
  assign bus.flush_d  = bus.redirect;
  assign bus.d_issue  = issue;

  // NOTE: the scoreboard is a small flop array, not a RAM, so it is cleared by reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      case (state)
        RUN:     if (bus.d_valid && bus.d_serialize && !bus.backend_empty && !bus.redirect)
                   state <= DRAIN;
        DRAIN:   if (bus.backend_empty || bus.redirect) state <= RUN;
        default: state <= RUN;
      endcase

      // Entry 0 is never written, so x0 never looks busy.
      for (int i = 1; i < 32; i++) begin
        if (inc && bus.d_rd_idx == 5'(i) && !(dec && bus.wb_rd_idx == 5'(i)))
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec && bus.wb_rd_idx == 5'(i) && !(inc && bus.d_rd_idx == 5'(i)) &&
                 cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // A writeback of a register with nothing in flight is a protocol error.
  wb_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.wb_valid && bus.wb_rd_we && bus.wb_rd_idx != 5'd0) |-> cnt[bus.wb_rd_idx] != '0);

endmodule

// File: tb/tb_letc_core_hazard_ctrl.sv
// Directed-vector bench for letc_core_hazard_ctrl with hand-computed output patterns.
module tb_letc_core_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  letc_core_hazard_ctrl_if bus ();

  letc_core_hazard_ctrl #(.CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Output bits: stall_f1 stall_f2 stall_d stall_e1 stall_e2 flush_f1 flush_f2 flush_d d_issue
  localparam logic [8:0] IDLE      = 9'b000_00_000_0;
  localparam logic [8:0] ISSUE     = 9'b000_00_000_1;
  localparam logic [8:0] STALL     = 9'b111_00_000_0;
  localparam logic [8:0] MEMST     = 9'b111_11_000_0;
  localparam logic [8:0] FLUSH     = 9'b000_00_111_0;
  localparam logic [8:0] FLUSH_MEM = 9'b000_11_111_0;

  function automatic logic [8:0] outs();
    return {bus.stall_f1, bus.stall_f2, bus.stall_d, bus.stall_e1, bus.stall_e2,
            bus.flush_f1, bus.flush_f2, bus.flush_d, bus.d_issue};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    #1;
    got = outs();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.d_valid = 0; bus.d_rs1_idx = 0; bus.d_rs2_idx = 0;
    bus.d_rs1_used = 0; bus.d_rs2_used = 0; bus.d_rd_idx = 0; bus.d_rd_we = 0;
    bus.d_serialize = 0; bus.wb_valid = 0; bus.wb_rd_we = 0; bus.wb_rd_idx = 0;
    bus.backend_empty = 0; bus.redirect = 0; bus.mem_stall = 0;
  endtask

  task automatic decode(input logic [4:0] rs1, input logic rs1u,
                        input logic [4:0] rs2, input logic rs2u,
                        input logic [4:0] rd, input logic we, input logic ser);
    bus.d_valid = 1; bus.d_rs1_idx = rs1; bus.d_rs1_used = rs1u;
    bus.d_rs2_idx = rs2; bus.d_rs2_used = rs2u;
    bus.d_rd_idx = rd; bus.d_rd_we = we; bus.d_serialize = ser;
  endtask

  task automatic wb(input logic on, input logic [4:0] rd);
    bus.wb_valid = on; bus.wb_rd_we = on; bus.wb_rd_idx = rd;
  endtask

  initial begin
    idle();
    check("reset_idle", IDLE);
    tick(); rst_n = 1'b1;
    check("post_reset_idle", IDLE);

    // RAW: addi x5 then add x6,x5,x0
    tick(); decode(5'd0, 1, 5'd0, 0, 5'd5, 1, 0);
    check("addi_x5_issue", ISSUE);
    tick(); decode(5'd5, 1, 5'd0, 1, 5'd6, 1, 0);
    check("raw_x5_c1", STALL);
    tick(); check("raw_x5_c2", STALL);
    tick(); wb(1, 5'd5);
    check("raw_x5_wb_cycle", STALL);
    tick(); wb(0, 5'd0);
    check("raw_x5_release", ISSUE);
    tick(); idle(); wb(1, 5'd6);
    tick(); wb(0, 5'd0);

    // Saturation of x7 at three in flight
    for (int k = 0; k < 3; k++) begin
      decode(5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
      check($sformatf("sat_x7_fill%0d", k), ISSUE);
      tick();
    end
    check("sat_x7_stall", STALL);
    wb(1, 5'd7);
    check("sat_x7_stall_wb", STALL);
    tick(); wb(0, 5'd0);
    check("sat_x7_release", ISSUE);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      wb(1, 5'd7); tick();
    end
    wb(0, 5'd0);
    decode(5'd7, 1, 5'd0, 0, 5'd0, 0, 0);
    check("x7_drained_read", ISSUE);
    tick(); idle();

    // Same-cycle issue and writeback of x9
    decode(5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    check("x9_first_issue", ISSUE);
    tick(); wb(1, 5'd9);
    check("x9_issue_with_wb", ISSUE);
    tick(); wb(0, 5'd0); decode(5'd0, 0, 5'd9, 1, 5'd0, 0, 0);
    check("x9_still_busy", STALL);
    tick(); idle(); wb(1, 5'd9);
    tick(); wb(0, 5'd0); decode(5'd0, 0, 5'd9, 1, 5'd0, 0, 0);
    check("x9_released", ISSUE);
    tick(); idle();

    // csrw mie waiting for an empty back end
    decode(5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ser_drain_c%0d", k), STALL);
      tick();
    end
    bus.backend_empty = 1;
    tick();
    check("ser_issue_after_drain", ISSUE);
    tick(); idle();
    decode(5'd0, 0, 5'd0, 0, 5'd0, 0, 1); bus.backend_empty = 1;
    check("ser_empty_issue", ISSUE);
    tick(); idle();

    // Redirect while stalled on RAW and in DRAIN
    decode(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    check("x5_issue_again", ISSUE);
    tick(); decode(5'd5, 1, 5'd0, 0, 5'd0, 0, 1);
    check("raw_and_ser", STALL);
    tick(); bus.redirect = 1;
    check("redirect_flush", FLUSH);
    tick(); bus.redirect = 0;
    decode(5'd0, 0, 5'd0, 0, 5'd0, 0, 1); bus.backend_empty = 1;
    check("fsm_run_after_redirect", ISSUE);
    tick(); idle(); decode(5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    check("x5_kept_after_redirect", STALL);
    bus.redirect = 1; bus.mem_stall = 1;
    check("redirect_mem_stall", FLUSH_MEM);
    bus.redirect = 0;
    check("mem_stall_with_hazard", MEMST);
    decode(5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
    check("mem_stall_no_hazard", MEMST);
    idle(); wb(1, 5'd5);
    tick(); wb(0, 5'd0);

    // x0 writes never occupy the scoreboard
    decode(5'd0, 0, 5'd0, 0, 5'd0, 1, 0); wb(1, 5'd0);
    check("x0_write_issue", ISSUE);
    tick(); wb(0, 5'd0); decode(5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
    check("x0_read_no_stall", ISSUE);
    tick(); idle();

    // Mid-operation reset clears a pending write
    decode(5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
    check("x3_issue", ISSUE);
    tick(); idle();
    rst_n = 1'b0;
    check("mid_reset_idle", IDLE);
    rst_n = 1'b1;
    decode(5'd3, 1, 5'd0, 0, 5'd0, 0, 0);
    check("x3_cleared_by_reset", ISSUE);
    tick(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/letc_core_hazard_ctrl.md
# letc_core_hazard_ctrl

Pipeline sequencing controller for the LETC core. It owns the `stage_stall`/`stage_flush` inputs of the F1, F2, D, E1 and E2 stages. It tracks in-flight register writes in a per-register scoreboard and stalls decode on RAW/WAW hazards. It serializes CSR/fence instructions and converts redirects and memory back-pressure into per-stage flush and stall controls.

## Interface
- `CNT_W`, default 2: width of each per-register in-flight counter; max in-flight writes per register = 2^CNT_W−1.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous active-low reset.
- `d_valid` in 1: decode holds a valid instruction (same as `f2_to_d_valid` registered in D).
- `d_rs1_idx`, `d_rs2_idx` in 5 each: decode source indices (`reg_idx_t`).
- `d_rs1_used`, `d_rs2_used` in 1 each: the source is actually read.
- `d_rd_idx` in 5: destination index.
- `d_rd_we` in 1: decode instruction writes rd.
- `d_serialize` in 1: decode instruction is CSR/fence/wfi and needs an empty back end.
- `wb_valid`, `wb_rd_we` in 1 each: writeback retires an instruction that writes rd.
- `wb_rd_idx` in 5: writeback destination.
- `backend_empty` in 1: E1, E2 and W hold no valid instruction.
- `redirect` in 1: E1 resolved a taken branch, jump or trap; front end must be discarded.
- `mem_stall` in 1: E2 is waiting on memory.
- `stall_f1`, `stall_f2`, `stall_d`, `stall_e1`, `stall_e2` out 1 each: stage stall.
- `flush_f1`, `flush_f2`, `flush_d` out 1 each: stage flush.
- `d_issue` out 1: the decode instruction advances to E1 this cycle.

## Operation
- Scoreboard: 32 counters `cnt[i]`, each `CNT_W` bits wide. `cnt[0]` is hardwired to 0.
  - Increment on `d_issue & d_rd_we & d_rd_idx!=0`.
  - Decrement on `wb_valid & wb_rd_we & wb_rd_idx!=0`.
  - Increment and decrement of the same index in one cycle leave the counter unchanged.
  - Decrement of a zero counter is a protocol error: flag it with an assertion and hold the counter at 0.
- `raw_hz = d_valid & ((d_rs1_used & cnt[rs1]!=0) | (d_rs2_used & cnt[rs2]!=0))`. There is no forwarding; any pending write blocks the read.
- `sat_hz = d_valid & d_rd_we & d_rd_idx!=0 & cnt[rd]==max`.
- Serialization FSM, states RUN and DRAIN:
  - RUN → DRAIN when `d_valid & d_serialize & !backend_empty & !redirect`.
  - DRAIN → RUN when `backend_empty` or `redirect`.
  - In DRAIN, `ser_hz = 1`.
  - In RUN, `ser_hz = d_valid & d_serialize & !backend_empty`.
- `d_hz = raw_hz | sat_hz | ser_hz`.
- Stall outputs:
  - `stall_e2 = stall_e1 = mem_stall`.
  - `stall_d = mem_stall | d_hz`; D emits a bubble to E1 while `d_hz` holds and `mem_stall` is low.
  - `stall_f2 = stall_f1 = stall_d`.
- Flush outputs: `flush_f1 = flush_f2 = flush_d = redirect`. Flush beats stall: when `redirect` is high, all front-end stall outputs are 0.
- `d_issue = d_valid & !stall_d & !redirect`.
- `redirect` never decrements the scoreboard. Flushed F1/F2/D instructions never issued, and the redirecting E1 instruction still retires.

## Timing
- Every output is combinational from current state and inputs; there is zero-cycle latency from hazard to stall.
- Counters and FSM update on `posedge clk`. A register written by an issuing instruction blocks the very next decode cycle.
- A writeback in cycle N releases a dependent decode in cycle N+1.
- Reset values:
  - All counters 0 and FSM in RUN.
  - With inputs low, every stall and flush output is 0 and `d_issue` is 0.
- Reset asserted mid-operation clears all scoreboard and FSM state immediately; any in-flight writeback afterwards is a bench error.
- `mem_stall` together with a hazard: no double counting, because `d_issue` is 0.
- `mem_stall` together with `redirect`: front-end flush outputs are 1 and front-end stall outputs are 0. E1/E2 stall.

## Test plan
- Reset with all inputs 0 → all outputs 0. Issue `addi x5` then decode `add x6,x5,x0` → `stall_d=1` every cycle until writeback of x5, then `d_issue=1` the cycle after.
- Issue three writes to x7 with `CNT_W=2` and no writeback → a fourth write to x7 gives `sat_hz`, so `stall_d=1`. One wb of x7 → the fourth write issues next cycle.
- Same-cycle issue of x9 and wb of x9 while `cnt[9]=1` → `cnt[9]` stays 1, and a later reader of x9 still stalls.
- Decode `csrw mie` with `backend_empty=0` for 3 cycles → FSM in DRAIN and `stall_d=1` for those 3 cycles. When `backend_empty=1`: `d_issue=1` and FSM back in RUN.
- `redirect=1` while D is stalled on RAW and in DRAIN → `flush_f1/f2/d=1`, `stall_f1/f2/d=0`, `d_issue=0`, FSM in RUN next cycle, counters unchanged.
- Write to x0 issued and wb to x0 → `cnt[0]` stays 0, and a reader of x0 never stalls.
